// File: rtl/flit_packer_enc.sv
// NIC flit packer: assigns per-packet sequence numbers, optionally XOR-encrypts, checks framing and buffers flits.
// Latency 1 cycle into an empty FIFO; in_ready drops only when the FIFO is full (no pass-through).
module flit_packer_enc #(
    parameter int PAYLOAD_W   = 32,
    parameter int FLIT_TYPE_W = 2,
    parameter int SN_W        = 5,
    parameter int XY_W        = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [PAYLOAD_W-1:0]                          payload,
    input  logic [FLIT_TYPE_W-1:0]                        flit_type,
    input  logic [2*XY_W-1:0]                             dest,
    input  logic [2*XY_W-1:0]                             src,
    input  logic                                          enc_en,
    input  logic                                          key_load,
    input  logic [PAYLOAD_W+SN_W+FLIT_TYPE_W-1:0]         key_in,
    output logic [PAYLOAD_W+SN_W+FLIT_TYPE_W+4*XY_W-1:0]  out_flit,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]                   fifo_count,
    output logic                                          err_seq,
    input  logic                                          err_clr
);
    localparam int E      = PAYLOAD_W + SN_W + FLIT_TYPE_W;
    localparam int FLIT_W = E + 4 * XY_W;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   E_U     = 32'(E);
    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t            r_state, w_state_nxt;
    logic [SN_W-1:0]   r_sn, w_sn;
    logic [E-1:0]      r_key;
    logic              r_err;
    logic              w_acc, w_push, w_pop, w_err;
    logic [1:0]        w_type;

    logic [FLIT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;

    logic [E-1:0]      w_plain, w_ks, w_enc;
    logic [2*E-1:0]    w_dbl;
    logic [31:0]       w_rot;

    assign w_type     = flit_type[1:0];
    assign in_ready   = (r_count != DEPTH_C);
    assign w_acc      = in_valid && in_ready;
    assign w_pop      = (r_count != '0) && out_ready;
    assign out_valid  = (r_count != '0);
    assign out_flit   = r_mem[r_rptr];
    assign fifo_count = r_count;
    assign err_seq    = r_err;

    // Misframed BODY/TAIL is consumed but dropped; misframed HEAD/SINGLE is kept and restarts numbering.
    always_comb begin
        w_state_nxt = r_state;
        w_sn        = r_sn;
        w_push      = 1'b0;
        w_err       = 1'b0;
        if (w_acc) begin
            case (w_type)
                T_HEAD, T_SINGLE: begin
                    w_err       = (r_state == IN_PKT);
                    w_sn        = '0;
                    w_push      = 1'b1;
                    w_state_nxt = (w_type == T_HEAD) ? IN_PKT : IDLE;
                end
                default: begin
                    if (r_state == IDLE) begin
                        w_err = 1'b1;
                    end else begin
                        w_sn   = r_sn + 1'b1;
                        w_push = 1'b1;
                        if (w_type == T_TAIL) w_state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // Rotate-left of the key by (SN mod E): upper half of the doubled key shifted left.
    assign w_plain = {payload, w_sn, flit_type};
    assign w_rot   = 32'(w_sn) % E_U;
    assign w_dbl   = {r_key, r_key} << w_rot;
    assign w_ks    = w_dbl[2*E-1:E];
    assign w_enc   = enc_en ? (w_plain ^ w_ks) : w_plain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sn    <= '0;
            r_key   <= '0;
            r_err   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sn    <= w_sn;
            if (key_load) r_key <= key_in;
            if (w_err) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wptr] <= {w_enc, dest, src};
    end

endmodule

// File: doc/flit_packer_enc.md
Name: flit_packer_enc

Overview:
Parametrised successor to the NIC packetiser. Accepts flits from the core NIC over a valid/ready handshake and generates each flit's sequence number (SN) internally. Optionally encrypts the {payload, SN, type} field with a rotating-key XOR cipher and enforces packet framing. Completed flits ({enc_field, dest, src}) are buffered in an output FIFO that the link controller drains over valid/ready.

Parameters:
PAYLOAD_W, 32, payload width in bits
FLIT_TYPE_W, 2, flit type width (must be >= 2)
SN_W, 5, sequence number width
XY_W, 4, width of one X or Y coordinate; dest and src are each 2*XY_W
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2)
Derived: E = PAYLOAD_W+SN_W+FLIT_TYPE_W (39 by default); FLIT_W = E+4*XY_W (55 by default)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  NIC presents a flit
in_ready  out  1  packer can accept a flit
payload  in  PAYLOAD_W  flit payload
flit_type  in  FLIT_TYPE_W  low 2 bits: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE; upper bits ignored
dest  in  2*XY_W  destination {x,y}
src  in  2*XY_W  source {x,y}
enc_en  in  1  encrypt flits accepted this cycle
key_load  in  1  load key_in into the key register
key_in  in  E  cipher key
out_flit  out  FLIT_W  FIFO head: {enc_field, dest, src}
out_valid  out  1  FIFO not empty
out_ready  in  1  link controller consumes the head
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
err_seq  out  1  sticky framing-error flag
err_clr  in  1  clears err_seq

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empties, fifo_count=0, out_valid=0, in_ready=1, err_seq=0, key=0, SN counter=0, FSM=IDLE. out_flit is don't-care while out_valid=0.
- Accept condition: in_valid && in_ready. in_ready = (fifo_count != FIFO_DEPTH); it is combinational and independent of in_valid.
- SN assignment:
  - HEAD or SINGLE gets SN=0.
  - BODY or TAIL gets SN = previous SN + 1, modulo 2^SN_W (wraps 31 -> 0).
- FSM states: IDLE, IN_PKT.
  - IDLE: HEAD -> IN_PKT; SINGLE -> IDLE.
  - IDLE: BODY or TAIL is a framing error. Set err_seq, drop the flit (it is consumed but not written to the FIFO), stay in IDLE, SN unchanged.
  - IN_PKT: BODY -> IN_PKT; TAIL -> IDLE.
  - IN_PKT: HEAD or SINGLE is a framing error. Set err_seq, but still write the flit. It starts a new packet with SN=0; next state is IN_PKT for HEAD, IDLE for SINGLE.
- Encryption: plain = {payload, SN, type}. ks = key rotated left by (SN mod E). enc_field = enc_en ? plain ^ ks : plain. enc_en and key are sampled in the accept cycle.
- Key update: when key_load coincides with an accept, the old key encrypts that flit and the new key applies from the next cycle.
- Latency: a flit accepted at edge t is visible on out_flit with out_valid=1 after edge t (1 cycle) when the FIFO was empty; otherwise it waits behind older entries in strict FIFO order.
- Pop: out_valid && out_ready. Popping on an empty FIFO is a no-op.
- Simultaneous push and pop: fifo_count is unchanged. At full, in_ready=0, so a same-cycle pop does not enable a push (no pass-through).
- Pointers wrap modulo FIFO_DEPTH.
- err_seq: if err_clr and a new error occur in the same cycle, the set wins.
- Reset mid-packet: the FSM returns to IDLE, so a following BODY flit is a framing error. Buffered flits are discarded.

Test Plan:
- Reset, then one SINGLE (payload=32'hDEADBEEF, dest=8'h21, src=8'h03, enc_en=0) -> after 1 cycle out_valid=1 and out_flit={32'hDEADBEEF, 5'd0, 2'b11, 8'h21, 8'h03}; pop -> out_valid=0.
- Packet HEAD, BODY x3, TAIL with out_ready=1 -> SN sequence 0,1,2,3,4; err_seq stays 0; FSM ends in IDLE.
- key_load with key_in=39'h1, then encrypted BODY with SN=2 -> enc_field = plain ^ 39'h4. Same flit with key=0 -> enc_field = plain.
- out_ready=0, push 5 flits with FIFO_DEPTH=4 -> in_ready=0 after the 4th and fifo_count=4; the 5th is held. Pop one -> in_ready=1; order is preserved.
- BODY from IDLE -> err_seq=1 and fifo_count unchanged. HEAD, then HEAD -> err_seq=1 and the second HEAD has SN=0. err_clr -> err_seq=0.
- Long packet of 34 flits -> SN wraps 31 -> 0 -> 1.
